// File: rtl/sl_rx_ctrl.sv
// Receiver control block: register interface, receiver configuration
// handshake FSM, received-word FIFO, sticky status and interrupt.
module sl_rx_ctrl #(
  parameter int FIFO_DEPTH  = 4,
  parameter int CFG_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  bus_addr,
  input  logic        bus_wr,
  input  logic        bus_rd,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_rvalid,
  output logic [15:0] rx_cfg_w,
  output logic        rx_cfg_wr,
  input  logic [15:0] rx_cfg_r,
  input  logic [15:0] rx_status,
  input  logic [31:0] rx_data,
  input  logic        rx_changed,
  output logic        irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(CFG_TIMEOUT + 1) + 1;

  typedef enum logic [1:0] {IDLE, PEND, CHECK} state_t;

  state_t          state, state_nxt;
  logic [TW-1:0]   timer, timer_nxt;
  logic            done_evt, timeout_evt;

  logic [31:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            empty, full;

  logic            ovf, unf, par_err, len_err, lev_err, cfg_err, cfg_done;
  logic [7:0]      irq_mask;
  logic [31:0]     rdata_nxt, stat_word, head;

  logic            wr_cfg, wr_stat, wr_mask, rd_data;
  logic            cfg_busy, cfg_bad, cfg_start;
  logic            push_req, push, pop;
  logic            ovf_set, unf_set, par_set, len_set, lev_set, cfg_err_set;
  logic [4:0]      irq_src;
  logic            unused_bits;

  assign unused_bits = ^{bus_wdata[31:18], rx_status[15:6], rx_status[2]};

  assign wr_cfg   = bus_wr && (bus_addr == 2'd0);
  assign wr_stat  = bus_wr && (bus_addr == 2'd2);
  assign wr_mask  = bus_wr && (bus_addr == 2'd3);
  assign rd_data  = bus_rd && (bus_addr == 2'd1);

  assign cfg_busy  = (state != IDLE);
  assign cfg_bad   = (bus_wdata[6:1] < 6'd8) || bus_wdata[1];
  assign cfg_start = wr_cfg && !cfg_busy && !cfg_bad;
  assign rx_cfg_wr = (state == PEND);

  assign empty = (count == '0);
  assign full  = (count == CW'(FIFO_DEPTH));
  assign head  = empty ? '0 : mem[rd_ptr];

  // Any error flag (including level error) suppresses the push.
  assign push_req = rx_changed && rx_status[3] && !rx_status[0]
                    && !rx_status[4] && !rx_status[5];
  assign pop      = rd_data && !empty;
  assign push     = push_req && (!full || pop);
  assign ovf_set  = push_req && full && !pop;
  assign unf_set  = rd_data && empty;
  assign par_set  = rx_changed && rx_status[4];
  assign len_set  = rx_changed && rx_status[0];
  assign lev_set  = rx_changed && rx_status[5];
  assign cfg_err_set = (wr_cfg && (cfg_busy || cfg_bad)) || timeout_evt;

  // Config FSM state and retry timer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
    end
  end

  // Config FSM next state: write, then check receiver echo until match or timeout.
  always_comb begin
    state_nxt   = state;
    timer_nxt   = timer;
    done_evt    = 1'b0;
    timeout_evt = 1'b0;
    unique case (state)
      IDLE: begin
        if (cfg_start) begin
          state_nxt = PEND;
          timer_nxt = '0;
        end
      end
      PEND: begin
        timer_nxt = timer + TW'(1);
        state_nxt = CHECK;
      end
      CHECK: begin
        if (rx_cfg_r == rx_cfg_w) begin
          state_nxt = IDLE;
          done_evt  = 1'b1;
        end else if (timer >= TW'(CFG_TIMEOUT)) begin
          state_nxt   = IDLE;
          timeout_evt = 1'b1;
        end else begin
          state_nxt = PEND;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the requested config word when a valid write starts the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_cfg_w <= 16'h0010;
    else if (cfg_start) rx_cfg_w <= bus_wdata[15:0];
  end

  // FIFO storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rx_data;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Sticky status bits: W1C clear, same-cycle set takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf      <= 1'b0;
      unf      <= 1'b0;
      par_err  <= 1'b0;
      len_err  <= 1'b0;
      lev_err  <= 1'b0;
      cfg_err  <= 1'b0;
      cfg_done <= 1'b0;
    end else begin
      ovf      <= (ovf      && !(wr_stat && bus_wdata[10])) || ovf_set;
      unf      <= (unf      && !(wr_stat && bus_wdata[11])) || unf_set;
      par_err  <= (par_err  && !(wr_stat && bus_wdata[12])) || par_set;
      len_err  <= (len_err  && !(wr_stat && bus_wdata[13])) || len_set;
      lev_err  <= (lev_err  && !(wr_stat && bus_wdata[14])) || lev_set;
      cfg_err  <= (cfg_err  && !(wr_stat && bus_wdata[16])) || cfg_err_set;
      cfg_done <= (cfg_done && !(wr_stat && bus_wdata[17])) || done_evt;
    end
  end

  // Interrupt mask register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_mask <= '0;
    else if (wr_mask) irq_mask <= bus_wdata[7:0];
  end

  assign stat_word = {14'b0, cfg_done, cfg_err, cfg_busy, lev_err, len_err,
                      par_err, unf, ovf, full, empty, 8'(count)};

  // Read data selection by register address.
  always_comb begin
    rdata_nxt = '0;
    unique case (bus_addr)
      2'd0: rdata_nxt = {15'b0, cfg_busy, rx_cfg_r};
      2'd1: rdata_nxt = head;
      2'd2: rdata_nxt = stat_word;
      2'd3: rdata_nxt = {24'b0, irq_mask};
      default: rdata_nxt = '0;
    endcase
  end

  // Registered read response, valid for the cycle after the strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_rdata  <= '0;
      bus_rvalid <= 1'b0;
    end else begin
      bus_rvalid <= bus_rd;
      if (bus_rd) bus_rdata <= rdata_nxt;
    end
  end

  assign irq_src = {cfg_err, cfg_done, par_err | len_err | lev_err, ovf, !empty};

  // Registered level interrupt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq <= 1'b0;
    else        irq <= |(irq_src & irq_mask[4:0]);
  end

endmodule

// File: tb/tb_sl_rx_ctrl.sv
// Scoreboard bench for sl_rx_ctrl: reads push expected data, a monitor
// compares on bus_rvalid; direct signal checks are queued to the same monitor.
module tb_sl_rx_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  bus_addr = '0;
  logic        bus_wr = 1'b0;
  logic        bus_rd = 1'b0;
  logic [31:0] bus_wdata = '0;
  logic [31:0] bus_rdata;
  logic        bus_rvalid;
  logic [15:0] rx_cfg_w;
  logic        rx_cfg_wr;
  logic [15:0] rx_cfg_r = '0;
  logic [15:0] rx_status = '0;
  logic [31:0] rx_data = '0;
  logic        rx_changed = 1'b0;
  logic        irq;

  sl_rx_ctrl #(.FIFO_DEPTH(4), .CFG_TIMEOUT(255)) dut (
    .clk(clk), .rst_n(rst_n), .bus_addr(bus_addr), .bus_wr(bus_wr),
    .bus_rd(bus_rd), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_rvalid(bus_rvalid), .rx_cfg_w(rx_cfg_w), .rx_cfg_wr(rx_cfg_wr),
    .rx_cfg_r(rx_cfg_r), .rx_status(rx_status), .rx_data(rx_data),
    .rx_changed(rx_changed), .irq(irq)
  );

  always #31 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } chk_t;

  logic [31:0] exp_q [$];
  string       name_q [$];
  chk_t        pend_q [$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          wr_total = 0;

  // Monitor: read responses against the scoreboard, then queued direct checks.
  always @(negedge clk) begin
    logic [31:0] e;
    string nm;
    chk_t c;
    if (rx_cfg_wr) wr_total++;
    if (bus_rvalid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_rvalid got %h expected no response", bus_rdata);
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (bus_rdata !== e) begin
          n_fail++;
          $display("FAIL %s got %h expected %h", nm, bus_rdata, e);
        end
      end
    end
    while (pend_q.size() > 0) begin
      c = pend_q.pop_front();
      n_checks++;
      if (c.act !== c.exp) begin
        n_fail++;
        $display("FAIL %s got %h expected %h", c.name, c.act, c.exp);
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_t c;
    c.name = nm;
    c.act  = act;
    c.exp  = exp;
    pend_q.push_back(c);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus_addr  = a;
    bus_wdata = d;
    bus_wr    = 1'b1;
    @(negedge clk);
    bus_wr    = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [31:0] e, input string nm);
    exp_q.push_back(e);
    name_q.push_back(nm);
    bus_addr = a;
    bus_rd   = 1'b1;
    @(negedge clk);
    bus_rd   = 1'b0;
  endtask

  task automatic rx_event(input logic [15:0] st, input logic [31:0] d);
    rx_status  = st;
    rx_data    = d;
    rx_changed = 1'b1;
    @(negedge clk);
    rx_changed = 1'b0;
    rx_status  = '0;
  endtask

  initial begin
    int base;
    #20_000_000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    repeat (3) @(negedge clk);
    check("rst_cfg_w", 32'(rx_cfg_w), 32'h0010);
    check("rst_cfg_wr", 32'(rx_cfg_wr), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_rvalid", 32'(bus_rvalid), 32'h0);
    check("rst_rdata", bus_rdata, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    bus_read(2'd2, 32'h0000_0100, "stat_reset");
    bus_read(2'd0, 32'h0000_0000, "cfg_reset");
    bus_read(2'd3, 32'h0000_0000, "mask_reset");

    // Config accepted after the receiver echoes it.
    base = wr_total;
    bus_write(2'd0, 32'h0000_0010);
    bus_read(2'd0, 32'h0001_0000, "cfg_busy");
    @(negedge clk);
    rx_cfg_r = 16'h0010;
    repeat (6) @(negedge clk);
    check("cfg_wr_pulses", 32'(wr_total - base), 32'd2);
    bus_read(2'd2, 32'h0002_0100, "stat_cfg_done");
    bus_read(2'd0, 32'h0000_0010, "cfg_idle");
    bus_write(2'd2, 32'h0002_0000);
    bus_read(2'd2, 32'h0000_0100, "stat_done_clr");

    // Rejected config words never drive the receiver.
    base = wr_total;
    bus_write(2'd0, 32'h0000_000E);
    repeat (3) @(negedge clk);
    bus_read(2'd2, 32'h0001_0100, "stat_bq7_err");
    bus_write(2'd2, 32'h0001_0000);
    bus_write(2'd0, 32'h0000_0012);
    repeat (3) @(negedge clk);
    bus_read(2'd2, 32'h0001_0100, "stat_bit1_err");
    bus_write(2'd2, 32'h0001_0000);
    check("rej_cfg_w", 32'(rx_cfg_w), 32'h0010);
    check("rej_wr_pulses", 32'(wr_total - base), 32'd0);

    // Receiver never echoes: busy write is ignored, then timeout.
    bus_write(2'd0, 32'h0000_0020);
    @(negedge clk);
    bus_write(2'd0, 32'h0000_0030);
    check("busy_wr_cfg_w", 32'(rx_cfg_w), 32'h0020);
    bus_read(2'd2, 32'h0001_8100, "stat_busy_wr_err");
    bus_write(2'd2, 32'h0001_0000);
    repeat (400) @(negedge clk);
    bus_read(2'd2, 32'h0000_8100, "stat_still_busy");
    repeat (200) @(negedge clk);
    bus_read(2'd2, 32'h0001_0100, "stat_timeout");
    check("timeout_cfg_wr", 32'(rx_cfg_wr), 32'h0);
    bus_write(2'd2, 32'h0001_0000);

    // Five words into a four-deep FIFO, then drain past empty.
    for (int i = 1; i <= 5; i++) rx_event(16'h0008, 32'(i));
    bus_read(2'd2, 32'h0000_0604, "stat_full_ovf");
    for (int i = 1; i <= 4; i++) bus_read(2'd1, 32'(i), "data_pop");
    bus_read(2'd1, 32'h0, "data_empty");
    bus_read(2'd2, 32'h0000_0D00, "stat_unf");
    bus_write(2'd2, 32'h0000_0C00);
    bus_read(2'd2, 32'h0000_0100, "stat_fifo_clr");

    // Push and pop in the same cycle while full.
    for (int i = 0; i < 4; i++) rx_event(16'h0008, 32'hA0 + 32'(i));
    exp_q.push_back(32'hA0);
    name_q.push_back("data_full_pushpop");
    bus_addr   = 2'd1;
    bus_rd     = 1'b1;
    rx_status  = 16'h0008;
    rx_data    = 32'hA4;
    rx_changed = 1'b1;
    @(negedge clk);
    bus_rd     = 1'b0;
    rx_changed = 1'b0;
    rx_status  = '0;
    bus_read(2'd2, 32'h0000_0204, "stat_pushpop_full");
    for (int i = 1; i <= 4; i++) bus_read(2'd1, 32'hA0 + 32'(i), "data_after_pushpop");
    bus_read(2'd2, 32'h0000_0100, "stat_drained");

    // Length error blocks the push.
    rx_event(16'h0009, 32'h55);
    bus_read(2'd2, 32'h0000_2100, "stat_len_err");
    bus_write(2'd2, 32'h0000_2000);

    // Parity error with interrupt masking and W1C.
    rx_event(16'h0018, 32'h77);
    bus_read(2'd2, 32'h0000_1100, "stat_par_err");
    bus_write(2'd3, 32'h0000_0004);
    check("irq_latency", 32'(irq), 32'h0);
    @(negedge clk);
    check("irq_par", 32'(irq), 32'h1);
    bus_read(2'd3, 32'h0000_0004, "mask_rb");
    bus_write(2'd2, 32'h0000_1000);
    @(negedge clk);
    check("irq_par_clr", 32'(irq), 32'h0);
    bus_read(2'd2, 32'h0000_0100, "stat_par_clr");

    // Non-empty interrupt source.
    bus_write(2'd3, 32'h0000_0001);
    @(negedge clk);
    check("irq_empty", 32'(irq), 32'h0);
    rx_event(16'h0008, 32'h99);
    @(negedge clk);
    check("irq_nonempty", 32'(irq), 32'h1);
    bus_read(2'd1, 32'h99, "data_irq_word");
    @(negedge clk);
    check("irq_drained", 32'(irq), 32'h0);
    bus_write(2'd3, 32'h0);

    // Reset during PEND aborts without status.
    rx_cfg_r = 16'h0000;
    bus_write(2'd0, 32'h0000_0020);
    check("pend_cfg_wr", 32'(rx_cfg_wr), 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_cfg_wr", 32'(rx_cfg_wr), 32'h0);
    check("abort_cfg_w", 32'(rx_cfg_w), 32'h0010);
    rst_n = 1'b1;
    @(negedge clk);
    bus_read(2'd2, 32'h0000_0100, "stat_after_abort");

    repeat (3) @(negedge clk);
    check("read_queue_empty", 32'(exp_q.size()), 32'h0);
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
